pretrig_capture_buffer: RTL and testbench

Single-clock, parametrised successor to the variable-width pre-trigger FIFO. Captures SAMPLE_W-bit ADC samples into a circular buffer while armed. On trigger, it freezes a run-time-selectable number of pre-trigger samples, then records the post-trigger samples. Read-out is in chronological order, one sample per read strobe. It sits between the ADC sample pipeline and the register/USB read-out path.

---
 rtl/pretrig_pkg.sv | 27 ++
 rtl/pretrig_dpram.sv | 31 +++
 rtl/pretrig_capture_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_pretrig_capture_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pretrig_pkg.sv
// Shared types and helpers for the pre-trigger capture buffer.
// State encoding, clamp helper and counter-width derivation.
package pretrig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READOUT,
        DONE
    } state_e;

    function automatic int cnt_w_for(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] clamp_u(
        input logic [31:0] v,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pretrig_dpram.sv
// Single-clock simple dual-port RAM with a registered read port.
// The read register only updates on re, so read data holds between reads.
module pretrig_dpram
    import pretrig_pkg::*;
#(
    parameter int W     = 10,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pretrig_capture_buffer.sv
// Circular pre-trigger capture buffer with chronological read-out.
// Optional sample decimation is enabled by defining DECIMATE_EN.
module pretrig_capture_buffer
    import pretrig_pkg::*;
#(
    parameter int SAMPLE_W = 10,
    parameter int DEPTH    = 1024,
    parameter int CNT_W    = cnt_w_for(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic [CNT_W-1:0]    pre_samples,
    input  logic [CNT_W-1:0]    total_samples,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                wr_ce,
    input  logic                trigger,
`ifdef DECIMATE_EN
    input  logic [7:0]          decim,
`endif
    output logic                armed,
    output logic                capture_done,
    output logic [CNT_W-1:0]    pre_actual,
    input  logic                rd_ce,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                rd_done
);

    localparam int PTR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PONE = PTR_W'(1);

    state_e state_q, state_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] pre_act_q, pre_act_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_done_q, rd_done_d;

    logic [CNT_W-1:0] tot_arm;
    logic [CNT_W-1:0] pre_arm;
    logic [CNT_W-1:0] post_len;
    logic [CNT_W-1:0] rd_total;
    logic             store;
    logic             ram_we;
    logic             ram_re;

`ifdef DECIMATE_EN
    logic [7:0] decim_q, decim_d;
    logic [7:0] phase_q, phase_d;

    // A trigger while armed forces its own sample to be kept.
    always_comb begin
        store = wr_ce && ((phase_q == 8'd0) ||
                          (trigger && state_q == ARMED));
    end

    always_comb begin
        decim_d = decim_q;
        phase_d = phase_q;
        if (arm) begin
            decim_d = decim;
            phase_d = 8'd0;
        end else if (wr_ce && (state_q == ARMED || state_q == CAPTURE)) begin
            if (store)
                phase_d = (decim_q == 8'd0) ? 8'd0 : 8'd1;
            else
                phase_d = (phase_q == decim_q) ? 8'd0 : phase_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_q <= 8'd0;
            phase_q <= 8'd0;
        end else begin
            decim_q <= decim_d;
            phase_q <= phase_d;
        end
    end
`else
    always_comb begin
        store = wr_ce;
    end
`endif

    always_comb begin
        tot_arm  = CNT_W'(clamp_u(32'(total_samples), 32'd1, 32'(DEPTH)));
        pre_arm  = (pre_samples < tot_arm - ONE) ? pre_samples : tot_arm - ONE;
        post_len = tot_q - pre_q;
        rd_total = pre_act_q + post_len;
    end

    always_comb begin
        state_d    = state_q;
        tot_d      = tot_q;
        pre_d      = pre_q;
        fill_d     = fill_q;
        post_cnt_d = post_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pre_act_d  = pre_act_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_done_d  = rd_done_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        if (arm) begin
            state_d    = ARMED;
            tot_d      = tot_arm;
            pre_d      = pre_arm;
            fill_d     = '0;
            post_cnt_d = '0;
            rd_cnt_d   = '0;
            pre_act_d  = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            rd_done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (store) begin
                        ram_we = 1'b1;
                        wptr_d = wptr_q + PONE;
                        if (trigger) begin
                            rptr_d     = wptr_q - fill_q[PTR_W-1:0];
                            pre_act_d  = fill_q;
                            post_cnt_d = ONE;
                            state_d    = (post_len == ONE) ? READOUT : CAPTURE;
                        end else if (fill_q != pre_q) begin
                            fill_d = fill_q + ONE;
                        end
                    end
                end
                CAPTURE: begin
                    if (store) begin
                        ram_we     = 1'b1;
                        wptr_d     = wptr_q + PONE;
                        post_cnt_d = post_cnt_q + ONE;
                        if (post_cnt_d == post_len) state_d = READOUT;
                    end
                end
                READOUT: begin
                    if (rd_ce) begin
                        ram_re     = 1'b1;
                        rptr_d     = rptr_q + PONE;
                        rd_cnt_d   = rd_cnt_q + ONE;
                        rd_valid_d = 1'b1;
                        if (rd_cnt_d == rd_total) begin
                            state_d   = DONE;
                            rd_done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tot_q      <= '0;
            pre_q      <= '0;
            fill_q     <= '0;
            post_cnt_q <= '0;
            rd_cnt_q   <= '0;
            pre_act_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tot_q      <= tot_d;
            pre_q      <= pre_d;
            fill_q     <= fill_d;
            post_cnt_q <= post_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pre_act_q  <= pre_act_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
            rd_done_q  <= rd_done_d;
        end
    end

    pretrig_dpram #(
        .W     (SAMPLE_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (rptr_q),
        .rdata (rd_data)
    );

    assign armed        = (state_q == ARMED) || (state_q == CAPTURE);
    assign capture_done = (state_q == READOUT) || (state_q == DONE);
    assign pre_actual   = pre_act_q;
    assign rd_valid     = rd_valid_q;
    assign rd_done      = rd_done_q;

endmodule

// File: tb/tb_pretrig_capture_buffer.sv
// Scoreboard bench for pretrig_capture_buffer: directed captures plus
// randomized captures against a queue-based model of the capture window.
module tb_pretrig_capture_buffer;

    localparam int SW    = 10;
    localparam int DEPTH = 128;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic [CW-1:0] pre_samples = '0;
    logic [CW-1:0] total_samples = '0;
    logic [SW-1:0] wr_data = '0;
    logic          wr_ce = 1'b0;
    logic          trigger = 1'b0;
    logic          rd_ce = 1'b0;
`ifdef DECIMATE_EN
    logic [7:0]    decim = 8'd0;
`endif
    logic          armed;
    logic          capture_done;
    logic [CW-1:0] pre_actual;
    logic [SW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_done;

    pretrig_capture_buffer #(
        .SAMPLE_W (SW),
        .DEPTH    (DEPTH),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .pre_samples   (pre_samples),
        .total_samples (total_samples),
        .wr_data       (wr_data),
        .wr_ce         (wr_ce),
        .trigger       (trigger),
`ifdef DECIMATE_EN
        .decim         (decim),
`endif
        .armed         (armed),
        .capture_done  (capture_done),
        .pre_actual    (pre_actual),
        .rd_ce         (rd_ce),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_done       (rd_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] d;
        bit            last;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 readout, 4 done
    int            m_mode = 0;
    int            m_tot, m_pre, m_pa, m_post_left, m_reads_left;
    int            m_k = 0;
    int            m_decim = 0;
    logic [SW-1:0] m_last = '0;
    logic [SW-1:0] hist[$];
    logic [SW-1:0] cap[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] rnd();
        return SW'($urandom_range(0, (1 << SW) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rd_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious rd_valid: got data %0d expected no read",
                             rd_data);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_done with rd_valid", rd_done, e.last);
                end
            end
        end
    end

    task automatic finish_capture();
        for (int i = 0; i < cap.size(); i++) begin
            exp_t e;
            e.d    = cap[i];
            e.last = (i == cap.size() - 1);
            sb.push_back(e);
        end
        m_reads_left = cap.size();
        m_last       = cap[cap.size() - 1];
        m_mode       = 3;
    endtask

    task automatic do_arm(input int p, input int t);
        m_tot = (t < 1) ? 1 : ((t > DEPTH) ? DEPTH : t);
        m_pre = (p < m_tot - 1) ? p : m_tot - 1;
        hist.delete();
        cap.delete();
        m_k    = 0;
        m_mode = 1;
`ifdef DECIMATE_EN
        m_decim = decim;
`endif
        arm           = 1'b1;
        pre_samples   = CW'(p);
        total_samples = CW'(t);
        wr_ce         = 1'b1;
        trigger       = 1'b1;
        rd_ce         = 1'b1;
        tick();
        arm     = 1'b0;
        wr_ce   = 1'b0;
        trigger = 1'b0;
        rd_ce   = 1'b0;
        chk("arm armed", armed, 1);
        chk("arm capture_done", capture_done, 0);
        chk("arm rd_done", rd_done, 0);
        chk("arm pre_actual", pre_actual, 0);
    endtask

    task automatic wr(input logic [SW-1:0] d, input bit trg);
        bit keep;
        bit fired;
        keep  = 1'b1;
        fired = 1'b0;
`ifdef DECIMATE_EN
        if (m_mode == 1 || m_mode == 2) begin
            keep = ((m_k % (m_decim + 1)) == 0) || (trg && m_mode == 1);
            m_k  = keep ? 1 : m_k + 1;
        end
`endif
        if (m_mode == 1 && keep) begin
            if (trg) begin
                m_pa = (hist.size() < m_pre) ? hist.size() : m_pre;
                for (int i = hist.size() - m_pa; i < hist.size(); i++)
                    cap.push_back(hist[i]);
                cap.push_back(d);
                m_post_left = m_tot - m_pre - 1;
                fired = 1'b1;
                if (m_post_left == 0) finish_capture();
                else m_mode = 2;
            end else begin
                hist.push_back(d);
            end
        end else if (m_mode == 2 && keep) begin
            cap.push_back(d);
            m_post_left--;
            if (m_post_left == 0) finish_capture();
        end
        wr_ce   = 1'b1;
        wr_data = d;
        trigger = trg;
        tick();
        wr_ce   = 1'b0;
        trigger = 1'b0;
        if (fired) begin
            chk("pre_actual", pre_actual, m_pa);
            chk("trigger capture_done", capture_done, m_mode == 3);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            trigger = $urandom_range(0, 1);
            wr_data = rnd();
            tick();
            trigger = 1'b0;
        end
    endtask

    task automatic read_one();
        bit ev;
        ev    = (m_mode == 3);
        rd_ce = 1'b1;
        tick();
        rd_ce = 1'b0;
        chk("rd_valid latency", rd_valid, ev);
        if (ev) begin
            m_reads_left--;
            if (m_reads_left == 0) m_mode = 4;
        end else if (m_mode == 4) begin
            chk("rd_data hold", rd_data, m_last);
        end
    endtask

    task automatic read_all();
        int guard;
        guard = 0;
        while (m_mode == 3 && guard < 2 * DEPTH) begin
            read_one();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            guard++;
        end
        read_one();
        idle(2);
        chk("done rd_done", rd_done, 1);
        chk("done capture_done", capture_done, 1);
        chk("done armed", armed, 0);
        chk("scoreboard drained", sb.size(), 0);
    endtask

    initial begin : main
        #12;
        chk("reset armed", armed, 0);
        chk("reset capture_done", capture_done, 0);
        chk("reset pre_actual", pre_actual, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_done", rd_done, 0);
        rst_n = 1'b1;
        tick();
        read_one();

        // Reference capture
        do_arm(3, 100);
        for (int v = 200; v <= 214; v++) wr(SW'(v), 1'b0);
        wr(SW'(999), 1'b1);
        for (int v = 700; v <= 849; v++) wr(SW'(v), 1'b0);
        read_all();

        // Trigger before the pre-window fills
        do_arm(8, 20);
        wr(SW'(5), 1'b0);
        wr(SW'(6), 1'b0);
        wr(SW'(7), 1'b1);
        for (int v = 8; v < 30; v++) wr(SW'(v), 1'b0);
        read_all();

        // Pointer wrap
        do_arm(4, 16);
        for (int v = 0; v < 140; v++) wr(SW'(v), 1'b0);
        wr(SW'(140), 1'b1);
        for (int v = 141; v <= 160; v++) wr(SW'(v), 1'b0);
        read_all();

        // Clamp low: only the trigger sample
        do_arm(20, 0);
        wr(SW'(77), 1'b0);
        wr(SW'(78), 1'b1);
        read_all();

        // Clamp high: full-depth capture
        do_arm(200, 255);
        for (int v = 0; v < 200; v++) wr(SW'(v), 1'b0);
        wr(SW'(300), 1'b1);
        read_all();

        // Abort mid-capture, then finish the new capture
        do_arm(2, 10);
        for (int v = 1; v < 5; v++) wr(SW'(v), 1'b0);
        wr(SW'(50), 1'b1);
        wr(SW'(51), 1'b0);
        do_arm(1, 5);
        wr(SW'(60), 1'b0);
        wr(SW'(61), 1'b1);
        for (int v = 62; v < 70; v++) wr(SW'(v), 1'b0);
        read_all();

        // Randomized captures
        for (int it = 0; it < 20; it++) begin
            int p, t, np, guard;
            p  = $urandom_range(0, DEPTH + 10);
            t  = $urandom_range(0, DEPTH + 20);
            np = $urandom_range(0, DEPTH + 40);
            do_arm(p, t);
            for (int i = 0; i < np; i++) begin
                wr(rnd(), 1'b0);
                if ($urandom_range(0, 7) == 0) idle(1);
                if ($urandom_range(0, 31) == 0) read_one();
            end
            wr(rnd(), 1'b1);
            guard = 0;
            while (m_mode == 2 && guard < 4 * DEPTH) begin
                wr(rnd(), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 5) == 0) idle(1);
                guard++;
            end
            chk("random capture_done", capture_done, 1);
            repeat ($urandom_range(0, 3)) wr(rnd(), 1'($urandom_range(0, 1)));
            read_all();
        end

        // Asynchronous reset during read-out
        do_arm(5, 30);
        for (int v = 0; v < 10; v++) wr(SW'(v + 400), 1'b0);
        wr(SW'(500), 1'b1);
        while (m_mode == 2) wr(rnd(), 1'b0);
        repeat (3) read_one();
        rd_ce = 1'b1;
        tick();
        rd_ce = 1'b0;
        chk("rd_valid before reset", rd_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset armed", armed, 0);
        chk("async reset capture_done", capture_done, 0);
        chk("async reset pre_actual", pre_actual, 0);
        chk("async reset rd_data", rd_data, 0);
        chk("async reset rd_valid", rd_valid, 0);
        chk("async reset rd_done", rd_done, 0);
        sb.delete();
        m_mode = 0;
        #1 rst_n = 1'b1;
        tick();
        chk("idle armed", armed, 0);
        chk("idle capture_done", capture_done, 0);
        read_one();
        wr(SW'(1), 1'b1);
        chk("idle pre_actual", pre_actual, 0);
        chk("idle armed after trigger", armed, 0);

`ifdef DECIMATE_EN
        decim = 8'd1;
        do_arm(2, 4);
        for (int v = 0; v < 10; v++) wr(SW'(v), v == 5);
        read_all();
        decim = 8'd0;
`endif

        idle(3);
        chk("final scoreboard empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
